// File: rtl/reg_file_wr_demux.sv
// rtl/reg_file_wr_demux.sv - register file with a 1-to-2**ADDR_W write demux and two combinational read ports
// Register 0 is hard-wired to zero. Optional write-to-read bypass is selected by BYPASS.
module reg_file_wr_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  we_dec;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // One-hot write select; entry 0 never enables so register 0 stays at its reset value.
  always_comb begin
    we_dec = '0;
    if (we && (wa != '0)) begin
      we_dec[wa] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else if (we_dec[i]) begin
        mem_q[i] <= wd;
      end
    end
  end

  // The reset gate matters with bypass on: wd must not leak onto the read ports while rst_n is low.
  always_comb begin
    rd1 = mem_q[ra1];
    if ((BYPASS != 0) && we && (wa == ra1)) begin
      rd1 = wd;
    end
    if (!rst_n || (ra1 == '0)) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if ((BYPASS != 0) && we && (wa == ra2)) begin
      rd2 = wd;
    end
    if (!rst_n || (ra2 == '0)) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// tb/tb_reg_file_wr_demux.sv - self-checking bench for reg_file_wr_demux, bypass and non-bypass builds
module tb_reg_file_wr_demux;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1_b;
  logic [31:0] rd2_b;
  logic [31:0] rd1_n;
  logic [31:0] rd2_n;

  logic [31:0] model [32];
  int n_checks;
  int n_fail;

  reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b)
  );

  reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] ra, input bit byp);
    if (!rst_n || ra == 5'd0) return 32'd0;
    if (byp && we && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_rd1_byp"},   rd1_b, expect_rd(ra1, 1'b1));
    check({tag, "_rd2_byp"},   rd2_b, expect_rd(ra2, 1'b1));
    check({tag, "_rd1_nobyp"}, rd1_n, expect_rd(ra1, 1'b0));
    check({tag, "_rd2_nobyp"}, rd2_n, expect_rd(ra2, 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    set_reset(1'b0);
    #2;
    ra1 = 5'd5; ra2 = 5'd17;
    #1;
    check_reads("reset_state");
    step();
    step();
    set_reset(1'b1);
    #1;

    // Test 1: reset clears immediately, also when it lands during a write
    write_reg(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("t1_written", rd1_n, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd5; wd = 32'h12345678;
    #2;
    set_reset(1'b0);
    #1;
    check("t1_async_rd1", rd1_b, 32'd0);
    check("t1_async_rd1_nobyp", rd1_n, 32'd0);
    check_reads("t1_in_reset");
    step();
    check_reads("t1_write_ignored");
    we = 1'b0;
    set_reset(1'b1);
    #1;
    check("t1_after_release", rd1_n, 32'd0);
    check_reads("t1_after_release");

    // Test 2: demux isolation
    for (int i = 1; i < 32; i++) write_reg(i[4:0], 32'h1000_0000 + i);
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = i[4:0];
      #1;
      check("t2_isolation", rd1_n, (i == 0) ? 32'd0 : 32'h1000_0000 + i);
      check_reads("t2_isolation");
    end

    // Test 3: register 0 is constant zero
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("t3_same_rd1_byp", rd1_b, 32'd0);
    check("t3_same_rd2_byp", rd2_b, 32'd0);
    step();
    we = 1'b0;
    #1;
    check("t3_after_rd1", rd1_n, 32'd0);
    check("t3_after_rd2", rd2_n, 32'd0);

    // Test 4: bypass behaviour
    write_reg(5'd7, 32'h11);
    we = 1'b1; wa = 5'd7; wd = 32'h22; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check("t4_before_byp", rd1_b, 32'h22);
    check("t4_before_nobyp", rd1_n, 32'h11);
    check_reads("t4_before");
    step();
    we = 1'b0;
    #1;
    check("t4_after_byp", rd1_b, 32'h22);
    check("t4_after_nobyp", rd1_n, 32'h22);

    // Test 5: we=0 never writes
    #2;
    set_reset(1'b0);
    #2;
    set_reset(1'b1);
    we = 1'b0; wa = 5'd9; wd = 32'hABCD; ra1 = 5'd9; ra2 = 5'd9;
    for (int i = 0; i < 3; i++) step();
    check("t5_r9_rd1", rd1_n, 32'd0);
    check("t5_r9_rd2", rd2_b, 32'd0);

    // Test 6: dual read, swap
    write_reg(5'd3, 32'hA5A5A5A5);
    write_reg(5'd4, 32'h5A5A5A5A);
    ra1 = 5'd3; ra2 = 5'd4;
    #1;
    check("t6_rd1_r3", rd1_n, 32'hA5A5A5A5);
    check("t6_rd2_r4", rd2_n, 32'h5A5A5A5A);
    ra1 = 5'd4; ra2 = 5'd3;
    #1;
    check("t6_rd1_r4", rd1_b, 32'h5A5A5A5A);
    check("t6_rd2_r3", rd2_b, 32'hA5A5A5A5);

    // Randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      #1;
      check_reads("rand");
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = 5'(31 - i);
      #1;
      check_reads("rand_final");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
